// File: rtl/riscv_defines.sv
`default_nettype none
// ============================================================================
// Module      : riscv_defines (package)
// Description : Shared widths, load/store type encodings, access sizes and
//               the write-back stage FSM state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_defines;

  localparam int WORD_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  // Load funct3 encodings; 011, 110 and 111 fall back to word loads
  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  // Store type encodings
  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } wb_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  // Access size of a load; unknown encodings behave as a word load
  function automatic acc_size_e load_size(input logic [2:0] lt);
    case (lt)
      LT_LB, LT_LBU: return SZ_BYTE;
      LT_LH, LT_LHU: return SZ_HALF;
      default:       return SZ_WORD;
    endcase
  endfunction

  // Access size of a store; the unused encoding behaves as a word store
  function automatic acc_size_e store_size(input logic [1:0] st);
    case (st)
      ST_SB:   return SZ_BYTE;
      ST_SH:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational byte-enable generation, store-data replication,
//               misalignment detection and load-data extraction.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
  import riscv_defines::*;
(
  input  logic        is_load_i,
  input  logic [2:0]  load_type_i,
  input  logic [1:0]  store_type_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);

  acc_size_e   size;
  logic [31:0] rdata_shifted;

  // Byte enables, replicated write data and alignment check by access size
  always_comb begin
    size         = is_load_i ? load_size(load_type_i) : store_size(store_type_i);
    be_o         = 4'hF;
    wdata_o      = store_data_i;
    misaligned_o = 1'b0;
    case (size)
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      SZ_HALF: begin
        be_o         = 4'b0011 << addr_lo_i;
        wdata_o      = {2{store_data_i[15:0]}};
        misaligned_o = addr_lo_i[0];
      end
      default: begin
        be_o         = 4'hF;
        wdata_o      = store_data_i;
        misaligned_o = |addr_lo_i;
      end
    endcase
  end

  // Move the addressed byte/halfword to bit 0, then sign- or zero-extend
  always_comb begin
    rdata_shifted = rdata_i >> {addr_lo_i, 3'b000};
    case (load_type_i)
      LT_LB:   load_data_o = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      LT_LBU:  load_data_o = {24'd0, rdata_shifted[7:0]};
      LT_LH:   load_data_o = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      LT_LHU:  load_data_o = {16'd0, rdata_shifted[15:0]};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage
// Description : Memory / write-back stage. ALU results go straight to the
//               register write port; loads and stores run a req/gnt/rvalid
//               handshake on the data bus before returning to IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage
  import riscv_defines::*;
#(
  parameter int WORD_WIDTH = riscv_defines::WORD_WIDTH,
  parameter int ADDR_WIDTH = riscv_defines::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [WORD_WIDTH-1:0] result_i,
  input  logic [WORD_WIDTH-1:0] store_data_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                  write_en_i,
  input  logic                  load_en_i,
  input  logic                  store_en_i,
  input  logic [2:0]            load_type_i,
  input  logic [1:0]            store_type_i,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  output logic [31:0]           data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [31:0]           data_wdata_o,
  input  logic [31:0]           data_rdata_i,
  output logic                  reg_wen_o,
  output logic [ADDR_WIDTH-1:0] reg_waddr_o,
  output logic [WORD_WIDTH-1:0] reg_wdata_o,
  output logic                  misaligned_o
);

  wb_state_e             state_q, state_d;
  logic                  data_req_q, data_req_d;
  logic                  data_we_q, data_we_d;
  logic [3:0]            data_be_q, data_be_d;
  logic [31:0]           data_addr_q, data_addr_d;
  logic [31:0]           data_wdata_q, data_wdata_d;
  logic                  reg_wen_q, reg_wen_d;
  logic [ADDR_WIDTH-1:0] reg_waddr_q, reg_waddr_d;
  logic [WORD_WIDTH-1:0] reg_wdata_q, reg_wdata_d;
  logic                  misaligned_q, misaligned_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [2:0]            load_type_q, load_type_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic                  is_load_q, is_load_d;

  logic        idle;
  logic        accept;
  logic        is_mem;
  logic [31:0] addr_in;
  logic        al_is_load;
  logic [2:0]  al_load_type;
  logic [1:0]  al_addr_lo;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load_data;
  logic        al_misaligned;

  assign idle    = (state_q == IDLE);
  assign accept  = valid_i & idle;
  assign is_mem  = load_en_i | store_en_i;
  assign addr_in = 32'(result_i);
  assign ready_o = idle;

  // In IDLE the aligner sees the incoming op; afterwards the latched load
  // attributes so the returning read data is extracted correctly.
  assign al_is_load   = idle ? load_en_i   : is_load_q;
  assign al_load_type = idle ? load_type_i : load_type_q;
  assign al_addr_lo   = idle ? addr_in[1:0] : addr_lo_q;

  lsu_align u_lsu_align (
    .is_load_i    (al_is_load),
    .load_type_i  (al_load_type),
    .store_type_i (store_type_i),
    .addr_lo_i    (al_addr_lo),
    .store_data_i (32'(store_data_i)),
    .rdata_i      (data_rdata_i),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .load_data_o  (al_load_data),
    .misaligned_o (al_misaligned)
  );

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      data_req_q   <= 1'b0;
      data_we_q    <= 1'b0;
      data_be_q    <= 4'd0;
      data_addr_q  <= 32'd0;
      data_wdata_q <= 32'd0;
      reg_wen_q    <= 1'b0;
      reg_waddr_q  <= '0;
      reg_wdata_q  <= '0;
      misaligned_q <= 1'b0;
      rd_q         <= '0;
      load_type_q  <= 3'd0;
      addr_lo_q    <= 2'd0;
      is_load_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_req_q   <= data_req_d;
      data_we_q    <= data_we_d;
      data_be_q    <= data_be_d;
      data_addr_q  <= data_addr_d;
      data_wdata_q <= data_wdata_d;
      reg_wen_q    <= reg_wen_d;
      reg_waddr_q  <= reg_waddr_d;
      reg_wdata_q  <= reg_wdata_d;
      misaligned_q <= misaligned_d;
      rd_q         <= rd_d;
      load_type_q  <= load_type_d;
      addr_lo_q    <= addr_lo_d;
      is_load_q    <= is_load_d;
    end
  end

  // Next-state: aligned memory ops wait for grant, loads then for rvalid
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && is_mem && !al_misaligned) state_d = WAIT_GNT;
      end
      WAIT_GNT: begin
        if (data_gnt_i) state_d = is_load_q ? WAIT_RVALID : IDLE;
      end
      WAIT_RVALID: begin
        if (data_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: bus fields hold their value; write and misalign are pulses
  always_comb begin
    data_req_d   = data_req_q;
    data_we_d    = data_we_q;
    data_be_d    = data_be_q;
    data_addr_d  = data_addr_q;
    data_wdata_d = data_wdata_q;
    reg_wen_d    = 1'b0;
    reg_waddr_d  = reg_waddr_q;
    reg_wdata_d  = reg_wdata_q;
    misaligned_d = 1'b0;
    rd_d         = rd_q;
    load_type_d  = load_type_q;
    addr_lo_d    = addr_lo_q;
    is_load_d    = is_load_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            reg_wen_d   = write_en_i && (rd_addr_i != '0);
            reg_waddr_d = rd_addr_i;
            reg_wdata_d = result_i;
          end else if (al_misaligned) begin
            misaligned_d = 1'b1;
          end else begin
            data_req_d   = 1'b1;
            data_we_d    = !load_en_i;
            data_be_d    = al_be;
            data_addr_d  = {addr_in[31:2], 2'b00};
            data_wdata_d = al_wdata;
            rd_d         = rd_addr_i;
            load_type_d  = load_type_i;
            addr_lo_d    = addr_in[1:0];
            is_load_d    = load_en_i;
          end
        end
      end
      WAIT_GNT: begin
        if (data_gnt_i) data_req_d = 1'b0;
      end
      WAIT_RVALID: begin
        if (data_rvalid_i) begin
          reg_wen_d   = (rd_q != '0);
          reg_waddr_d = rd_q;
          reg_wdata_d = WORD_WIDTH'(al_load_data);
        end
      end
      default: data_req_d = 1'b0;
    endcase
  end

  assign data_req_o   = data_req_q;
  assign data_we_o    = data_we_q;
  assign data_be_o    = data_be_q;
  assign data_addr_o  = data_addr_q;
  assign data_wdata_o = data_wdata_q;
  assign reg_wen_o    = reg_wen_q;
  assign reg_waddr_o  = reg_waddr_q;
  assign reg_wdata_o  = reg_wdata_q;
  assign misaligned_o = misaligned_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage
// Description : Self-checking bench for wb_stage: directed scenarios plus
//               randomized transactions against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] result_i = '0;
  logic [31:0] store_data_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        write_en_i = 1'b0;
  logic        load_en_i = 1'b0;
  logic        store_en_i = 1'b0;
  logic [2:0]  load_type_i = '0;
  logic [1:0]  store_type_i = '0;
  logic        data_req_o;
  logic        data_gnt_i = 1'b0;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic [31:0] data_rdata_i = '0;
  logic        reg_wen_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;
  logic        misaligned_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_stage #(.WORD_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .result_i      (result_i),
    .store_data_i  (store_data_i),
    .rd_addr_i     (rd_addr_i),
    .write_en_i    (write_en_i),
    .load_en_i     (load_en_i),
    .store_en_i    (store_en_i),
    .load_type_i   (load_type_i),
    .store_type_i  (store_type_i),
    .data_req_o    (data_req_o),
    .data_gnt_i    (data_gnt_i),
    .data_rvalid_i (data_rvalid_i),
    .data_addr_o   (data_addr_o),
    .data_we_o     (data_we_o),
    .data_be_o     (data_be_o),
    .data_wdata_o  (data_wdata_o),
    .data_rdata_i  (data_rdata_i),
    .reg_wen_o     (reg_wen_o),
    .reg_waddr_o   (reg_waddr_o),
    .reg_wdata_o   (reg_wdata_o),
    .misaligned_o  (misaligned_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic int acc_size(input bit is_load, input logic [2:0] lt, input logic [1:0] st);
    if (is_load) begin
      if (lt == 3'd0 || lt == 3'd4) return 1;
      if (lt == 3'd1 || lt == 3'd5) return 2;
      return 4;
    end
    if (st == 2'd0) return 1;
    if (st == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] model_be(input int size, input int off);
    int m;
    m = ((1 << size) - 1) << off;
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input int size, input logic [31:0] d);
    if (size == 1) return (d & 32'hFF) * 32'h01010101;
    if (size == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] lt, input int off, input logic [31:0] rdata);
    int          size;
    logic [31:0] v;
    size = acc_size(1'b1, lt, 2'd0);
    v = rdata >> (8 * off);
    if (size == 1) begin
      v = v & 32'hFF;
      if (lt == 3'd0 && v >= 32'd128) v = v - 32'd256;
    end else if (size == 2) begin
      v = v & 32'hFFFF;
      if (lt == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  // Idle cycles with junk on the unqualified inputs (optionally stray rvalid)
  task automatic idle_cycles(input int n, input bit stray_rvalid);
    for (int i = 0; i < n; i++) begin
      valid_i       = 1'b0;
      result_i      = $urandom;
      store_data_i  = $urandom;
      rd_addr_i     = 5'($urandom);
      write_en_i    = 1'($urandom);
      load_en_i     = 1'($urandom);
      store_en_i    = 1'($urandom);
      load_type_i   = 3'($urandom);
      store_type_i  = 2'($urandom);
      data_rvalid_i = stray_rvalid;
      data_rdata_i  = $urandom;
      step();
      data_rvalid_i = 1'b0;
      check("idle_wen", 32'(reg_wen_o), 32'd0);
      check("idle_mis", 32'(misaligned_o), 32'd0);
      check("idle_req", 32'(data_req_o), 32'd0);
      check("idle_ready", 32'(ready_o), 32'd1);
    end
  endtask

  // kind: 0 ALU, 1 load, 2 store, 3 load+store (treated as load)
  task automatic run_txn(input int kind, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [2:0] lt, input logic [1:0] st, input logic [4:0] rd,
                         input logic we, input int gnt_dly, input int rv_dly,
                         input logic [31:0] rdata, input bit stray_gnt);
    bit          is_load;
    int          size;
    int          off;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    valid_i      = 1'b1;
    result_i     = addr;
    store_data_i = sdata;
    rd_addr_i    = rd;
    write_en_i   = we;
    load_en_i    = (kind == 1 || kind == 3);
    store_en_i   = (kind == 2 || kind == 3);
    load_type_i  = lt;
    store_type_i = st;
    step();
    valid_i      = 1'b0;
    result_i     = $urandom;
    store_data_i = $urandom;
    rd_addr_i    = 5'($urandom);
    load_en_i    = 1'($urandom);
    store_en_i   = 1'($urandom);
    load_type_i  = 3'($urandom);
    store_type_i = 2'($urandom);

    if (kind == 0) begin
      check("alu_wen", 32'(reg_wen_o), 32'(we && rd != 5'd0));
      if (we && rd != 5'd0) begin
        check("alu_waddr", 32'(reg_waddr_o), 32'(rd));
        check("alu_wdata", reg_wdata_o, addr);
      end
      check("alu_req", 32'(data_req_o), 32'd0);
      check("alu_ready", 32'(ready_o), 32'd1);
      return;
    end

    is_load  = (kind != 2);
    size     = acc_size(is_load, lt, st);
    off      = int'(addr[1:0]);
    exp_addr = addr & 32'hFFFF_FFFC;
    exp_be   = model_be(size, off);

    if ((off % size) != 0) begin
      check("mis_pulse", 32'(misaligned_o), 32'd1);
      check("mis_req", 32'(data_req_o), 32'd0);
      check("mis_wen", 32'(reg_wen_o), 32'd0);
      check("mis_ready", 32'(ready_o), 32'd1);
      step();
      check("mis_pulse_end", 32'(misaligned_o), 32'd0);
      check("mis_req2", 32'(data_req_o), 32'd0);
      check("mis_wen2", 32'(reg_wen_o), 32'd0);
      return;
    end

    check("mem_req", 32'(data_req_o), 32'd1);
    check("mem_ready", 32'(ready_o), 32'd0);
    check("mem_addr", data_addr_o, exp_addr);
    check("mem_be", 32'(data_be_o), 32'(exp_be));
    check("mem_we", 32'(data_we_o), 32'(!is_load));
    if (!is_load) check("mem_wdata", data_wdata_o, model_wdata(size, sdata));
    check("mem_mis", 32'(misaligned_o), 32'd0);

    for (int i = 0; i < gnt_dly; i++) begin
      step();
      check("req_hold", 32'(data_req_o), 32'd1);
      check("addr_hold", data_addr_o, exp_addr);
      check("be_hold", 32'(data_be_o), 32'(exp_be));
    end
    data_gnt_i = 1'b1;
    step();
    data_gnt_i = 1'b0;
    check("req_drop", 32'(data_req_o), 32'd0);

    if (!is_load) begin
      check("st_ready", 32'(ready_o), 32'd1);
      check("st_wen", 32'(reg_wen_o), 32'd0);
      return;
    end

    check("ld_wait_ready", 32'(ready_o), 32'd0);
    for (int i = 0; i < rv_dly; i++) begin
      data_gnt_i = stray_gnt;
      step();
      check("ld_wait_wen", 32'(reg_wen_o), 32'd0);
      check("ld_wait_ready", 32'(ready_o), 32'd0);
      check("ld_wait_req", 32'(data_req_o), 32'd0);
    end
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b1;
    data_rdata_i  = rdata;
    step();
    data_rvalid_i = 1'b0;
    data_rdata_i  = $urandom;
    check("ld_wen", 32'(reg_wen_o), 32'(rd != 5'd0));
    if (rd != 5'd0) begin
      check("ld_waddr", 32'(reg_waddr_o), 32'(rd));
      check("ld_wdata", reg_wdata_o, model_load(lt, off, rdata));
    end
    check("ld_ready", 32'(ready_o), 32'd1);
  endtask

  initial begin
    int r, kind;

    // Reset state
    #12;
    check("rst_req", 32'(data_req_o), 32'd0);
    check("rst_we", 32'(data_we_o), 32'd0);
    check("rst_be", 32'(data_be_o), 32'd0);
    check("rst_addr", data_addr_o, 32'd0);
    check("rst_wdata", data_wdata_o, 32'd0);
    check("rst_wen", 32'(reg_wen_o), 32'd0);
    check("rst_waddr", 32'(reg_waddr_o), 32'd0);
    check("rst_rwdata", reg_wdata_o, 32'd0);
    check("rst_mis", 32'(misaligned_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd1);
    step();
    rst = 1'b0;
    idle_cycles(2, 1'b0);

    // ALU write, then ALU write to x0
    run_txn(0, 32'h1234, 32'h0, 3'd0, 2'd0, 5'd5, 1'b1, 0, 0, 32'h0, 1'b0);
    run_txn(0, 32'h1234, 32'h0, 3'd0, 2'd0, 5'd0, 1'b1, 0, 0, 32'h0, 1'b0);
    idle_cycles(1, 1'b0);

    // LB / LBU at 0x103, grant after 2 cycles
    run_txn(1, 32'h103, 32'h0, 3'b000, 2'd0, 5'd7, 1'b1, 2, 1, 32'h80FF_FFFF, 1'b0);
    check("lb_value", reg_wdata_o, 32'hFFFF_FF80);
    run_txn(1, 32'h103, 32'h0, 3'b100, 2'd0, 5'd7, 1'b1, 2, 1, 32'h80FF_FFFF, 1'b0);
    check("lbu_value", reg_wdata_o, 32'h0000_0080);

    // SH at 0x202, immediate grant
    run_txn(2, 32'h202, 32'hABCD_1234, 3'd0, 2'b01, 5'd9, 1'b1, 0, 0, 32'h0, 1'b0);
    check("sh_be", 32'(data_be_o), 32'h0000_000C);
    check("sh_wdata", data_wdata_o, 32'h1234_1234);
    idle_cycles(1, 1'b0);

    // Misaligned LW
    run_txn(1, 32'h101, 32'h0, 3'b010, 2'd0, 5'd4, 1'b1, 0, 0, 32'h0, 1'b0);

    // Reset while waiting for rvalid, then a late rvalid
    valid_i = 1'b1; result_i = 32'h40; rd_addr_i = 5'd3; load_en_i = 1'b1;
    store_en_i = 1'b0; load_type_i = 3'b010; write_en_i = 1'b1;
    step();
    valid_i = 1'b0; load_en_i = 1'b0;
    check("rr_req", 32'(data_req_o), 32'd1);
    data_gnt_i = 1'b1;
    step();
    data_gnt_i = 1'b0;
    check("rr_wait", 32'(ready_o), 32'd0);
    rst = 1'b1;
    #1;
    check("rr_req0", 32'(data_req_o), 32'd0);
    check("rr_wen0", 32'(reg_wen_o), 32'd0);
    check("rr_ready", 32'(ready_o), 32'd1);
    step();
    rst = 1'b0;
    data_rvalid_i = 1'b1; data_rdata_i = 32'hDEAD_BEEF;
    step();
    data_rvalid_i = 1'b0;
    check("rr_late_wen", 32'(reg_wen_o), 32'd0);
    check("rr_late_ready", 32'(ready_o), 32'd1);
    idle_cycles(1, 1'b0);

    // Stray rvalid in IDLE, stray gnt in WAIT_RVALID
    idle_cycles(2, 1'b1);
    run_txn(1, 32'h300, 32'h0, 3'b010, 2'd0, 5'd12, 1'b1, 1, 3, 32'h1357_9BDF, 1'b1);
    idle_cycles(1, 1'b0);

    // Back-to-back: load then ALU accepted on re-entry to IDLE
    run_txn(1, 32'h402, 32'h0, 3'b001, 2'd0, 5'd6, 1'b1, 0, 0, 32'h8001_7FFF, 1'b0);
    run_txn(0, 32'hCAFE_0001, 32'h0, 3'd0, 2'd0, 5'd8, 1'b1, 0, 0, 32'h0, 1'b0);
    run_txn(0, 32'hCAFE_0002, 32'h0, 3'd0, 2'd0, 5'd9, 1'b1, 0, 0, 32'h0, 1'b0);
    idle_cycles(1, 1'b0);

    // Randomized transactions
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 2)      kind = 0;
      else if (r <= 5) kind = 1;
      else if (r <= 8) kind = 2;
      else             kind = 3;
      run_txn(kind, $urandom, $urandom, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 2)),
              5'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom, 1'($urandom));
      idle_cycles($urandom_range(0, 2), 1'($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter WORD_WIDTH, default 32, data and result width.
REQ-002 Parameter ADDR_WIDTH, default 5, register-index width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 valid_i  in  1  instruction from EX is present.
REQ-006 ready_o  out  1  stage accepts an instruction this cycle.
REQ-007 result_i  in  WORD_WIDTH  ALU result; effective address for loads and stores.
REQ-008 store_data_i  in  WORD_WIDTH  rs2 value for stores.
REQ-009 rd_addr_i  in  ADDR_WIDTH  destination register.
REQ-010 write_en_i / load_en_i / store_en_i  in  1 each  register-write, load and store qualifiers.
REQ-011 load_type_i  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-012 store_type_i  in  2  00 SB, 01 SH, 10 SW.
REQ-013 data_req_o out 1, data_gnt_i in 1, data_rvalid_i in 1  data-memory handshake.
REQ-014 data_addr_o out 32, data_we_o out 1, data_be_o out 4, data_wdata_o out 32, data_rdata_i in 32  data-memory bus.
REQ-015 reg_wen_o out 1, reg_waddr_o out ADDR_WIDTH, reg_wdata_o out WORD_WIDTH  register-bank write port.
REQ-016 misaligned_o  out  1  one-cycle misaligned-access pulse.

Function
REQ-017 The FSM SHALL have the states IDLE, WAIT_GNT and WAIT_RVALID; ready_o SHALL be 1 only in IDLE.
REQ-018 Accept = valid_i and ready_o; non-accepted inputs SHALL be ignored.
REQ-019 On an accepted ALU op (no load_en_i, no store_en_i), reg_wen_o SHALL be (write_en_i and rd_addr_i != 0) in the next cycle, with reg_wdata_o = result_i; the FSM SHALL remain in IDLE.
REQ-020 reg_wen_o and misaligned_o SHALL each be single-cycle registered pulses.
REQ-021 On an accepted aligned load or store, the stage SHALL latch the address, data, type and rd, and SHALL go to WAIT_GNT.
REQ-022 In WAIT_GNT, data_req_o SHALL be 1 and all data_* outputs SHALL stay stable until data_gnt_i.
REQ-023 On gnt, a store SHALL return to IDLE and a load SHALL go to WAIT_RVALID; data_req_o SHALL drop the cycle after gnt.
REQ-024 In WAIT_RVALID, on data_rvalid_i the stage SHALL register the extracted load data to the write port (reg_wen_o the next cycle, suppressed for rd 0) and SHALL return to IDLE.
REQ-025 data_rvalid_i outside WAIT_RVALID and data_gnt_i outside WAIT_GNT SHALL be ignored.
REQ-026 data_addr_o SHALL be {addr[31:2],2'b00}; data_we_o SHALL be 1 for stores.
REQ-027 data_be_o SHALL be 0001<<addr[1:0] for SB, 0011<<addr[1:0] for SH, and 1111 for SW; loads SHALL use the same masks.
REQ-028 data_wdata_o SHALL be the byte replicated 4 times for SB, the halfword replicated 2 times for SH, and the word for SW.
REQ-029 Load extraction SHALL select the byte or halfword at addr[1:0]; LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend. Encodings 011, 110 and 111 SHALL be treated as LW.
REQ-030 Misaligned access (H with addr[0]=1, W with addr[1:0]!=0) SHALL issue no request and no register write, SHALL pulse misaligned_o the next cycle, and SHALL stay in IDLE.
REQ-031 If load_en_i and store_en_i are both 1, the access SHALL be treated as a load.
REQ-032 A back-to-back ALU op accepted in the cycle the FSM re-enters IDLE SHALL write in the following cycle, with no lost or merged writes.

Reset
REQ-033 While rst is high, the FSM SHALL be IDLE and all registered outputs (data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o, reg_wen_o, reg_waddr_o, reg_wdata_o, misaligned_o) SHALL be 0; ready_o SHALL be 1.
REQ-034 Reset asserted mid-transaction SHALL abandon the transaction immediately, with no later register write.

Structure
REQ-035 WORD_WIDTH, ADDR_WIDTH, the load/store type encodings and the FSM state enum SHALL live in the shared package riscv_defines.
REQ-036 Byte-enable generation, store replication and load extraction SHALL be one combinational sub-module, lsu_align.

Verification
REQ-037 ALU op: result_i=0x1234, rd=5, write_en=1 -> next cycle reg_wen=1, waddr=5, wdata=0x1234; with rd=0 -> reg_wen stays 0.
REQ-038 LB at 0x103, gnt after 2 cycles, rdata=0x80FFFFFF -> addr=0x100, be=1000, wdata to reg=0xFFFFFF80; LBU -> 0x00000080.
REQ-039 SH at 0x202, store_data=0xABCD1234, gnt immediate -> be=1100, wdata=0x12341234, we=1, back in IDLE the cycle after gnt, no reg write.
REQ-040 LW at 0x101 -> no data_req, misaligned pulse 1 cycle, no reg write, ready_o stays 1.
REQ-041 rst asserted in WAIT_RVALID, then rvalid -> req=0, no reg_wen, ready_o=1.
REQ-042 Stray rvalid in IDLE, and gnt held high for 3 cycles in WAIT_RVALID -> no effect; a single write occurs on the real rvalid.
